// File: rtl/cache_pkg.sv
// Shared types for the set-associative cache controller: MESI states, op codes, FSM states.
package cache_pkg;

  typedef enum logic [1:0] {
    MESI_I = 2'd0,
    MESI_S = 2'd1,
    MESI_E = 2'd2,
    MESI_M = 2'd3
  } mesi_t;

  localparam logic [3:0] OP_READ    = 4'd0;
  localparam logic [3:0] OP_WRITE   = 4'd1;
  localparam logic [3:0] OP_SNP_INV = 4'd3;
  localparam logic [3:0] OP_SNP_RD  = 4'd4;
  localparam logic [3:0] OP_FLUSH   = 4'd8;

  typedef enum logic [1:0] {
    ST_FLUSH  = 2'd0,
    ST_IDLE   = 2'd1,
    ST_LOOKUP = 2'd2,
    ST_UPDATE = 2'd3
  } fsm_t;

endpackage

// File: rtl/assoc_cache_ctrl_if.sv
// Request/response, writeback and statistics bundle of the cache controller.
interface assoc_cache_ctrl_if #(
  parameter int unsigned IDX_W = 14,
  parameter int unsigned TAG_W = 12,
  parameter int unsigned WAY_W = 3,
  parameter int unsigned CNT_W = 32
);
  logic             req_valid;
  logic             req_ready;
  logic [3:0]       req_op;
  logic [IDX_W-1:0] req_index;
  logic [TAG_W-1:0] req_tag;
  logic             rsp_valid;
  logic             rsp_hit;
  logic [WAY_W-1:0] rsp_way;
  logic [1:0]       rsp_state;
  logic             evict_wb;
  logic [IDX_W-1:0] evict_index;
  logic [TAG_W-1:0] evict_tag;
  logic [CNT_W-1:0] stat_hit;
  logic [CNT_W-1:0] stat_miss;
  logic [CNT_W-1:0] stat_read;
  logic [CNT_W-1:0] stat_write;

  modport master (
    output req_valid, req_op, req_index, req_tag,
    input  req_ready, rsp_valid, rsp_hit, rsp_way, rsp_state,
    input  evict_wb, evict_index, evict_tag,
    input  stat_hit, stat_miss, stat_read, stat_write
  );

  modport slave (
    input  req_valid, req_op, req_index, req_tag,
    output req_ready, rsp_valid, rsp_hit, rsp_way, rsp_state,
    output evict_wb, evict_index, evict_tag,
    output stat_hit, stat_miss, stat_read, stat_write
  );
endinterface

// File: rtl/cache_lru_update.sv
// Victim choice (lowest invalid way, else LRU rank 0) and rank update for touching a way.
module cache_lru_update #(
  parameter  int unsigned WAYS  = 8,
  localparam int unsigned WAY_W = $clog2(WAYS)
) (
  input  logic [WAYS-1:0]            inv_vec,
  input  logic [WAYS-1:0][WAY_W-1:0] rank_in,
  input  logic                       hit,
  input  logic [WAY_W-1:0]           hit_way,
  output logic [WAY_W-1:0]           tgt_way_c,
  output logic [WAYS-1:0][WAY_W-1:0] rank_out_c
);

  logic [WAY_W-1:0] victim_way;
  logic             found;

  always_comb begin
    victim_way = '0;
    found      = 1'b0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!found && inv_vec[w]) begin
        victim_way = WAY_W'(w);
        found      = 1'b1;
      end
    end
    if (!found) begin
      for (int unsigned w = 0; w < WAYS; w++) begin
        if (rank_in[w] == '0) victim_way = WAY_W'(w);
      end
    end
  end

  assign tgt_way_c = hit ? hit_way : victim_way;

  // Ways more recent than the touched one slide down; the touched way becomes MRU.
  always_comb begin
    rank_out_c = rank_in;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (rank_in[w] > rank_in[tgt_way_c]) rank_out_c[w] = rank_in[w] - WAY_W'(1);
    end
    rank_out_c[tgt_way_c] = WAY_W'(WAYS - 1);
  end

endmodule

// File: rtl/assoc_cache_ctrl.sv
// Set-associative MESI tag/state controller with LRU replacement, flush walk and statistics.
module assoc_cache_ctrl
  import cache_pkg::*;
#(
  parameter  int unsigned WAYS  = 8,
  parameter  int unsigned SETS  = 16384,
  parameter  int unsigned TAG_W = 12,
  parameter  int unsigned CNT_W = 32,
  localparam int unsigned IDX_W = $clog2(SETS),
  localparam int unsigned WAY_W = $clog2(WAYS)
) (
  input logic clk,
  input logic rst_n,
  assoc_cache_ctrl_if.slave bus
);

  fsm_t             state_q, state_d;
  logic [IDX_W-1:0] flush_idx_q;
  logic [3:0]       op_q;
  logic [IDX_W-1:0] idx_q;
  logic [TAG_W-1:0] tag_q;

  logic             ready_q, rsp_valid_q, rsp_hit_q, evict_wb_q;
  logic [WAY_W-1:0] rsp_way_q;
  mesi_t            rsp_state_q;
  logic [IDX_W-1:0] evict_index_q;
  logic [TAG_W-1:0] evict_tag_q;
  logic [CNT_W-1:0] stat_hit_q, stat_miss_q, stat_read_q, stat_write_q;

  // Tag/state/rank arrays: no reset, made valid only by the flush walk.
  logic [TAG_W-1:0] tag_mem  [SETS][WAYS];
  mesi_t            st_mem   [SETS][WAYS];
  logic [WAY_W-1:0] rank_mem [SETS][WAYS];

  logic [WAYS-1:0]            inv_vec, hit_vec;
  logic [WAYS-1:0][WAY_W-1:0] rank_cur, rank_new;
  logic                       hit;
  logic [WAY_W-1:0]           hit_way, tgt_way;
  mesi_t                      tgt_st;

  always_comb begin
    hit_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      inv_vec[w]  = (st_mem[idx_q][w] == MESI_I);
      hit_vec[w]  = !inv_vec[w] && (tag_mem[idx_q][w] == tag_q);
      rank_cur[w] = rank_mem[idx_q][w];
    end
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (hit_vec[w]) hit_way = WAY_W'(w);
    end
  end

  assign hit = |hit_vec;

  cache_lru_update #(.WAYS(WAYS)) u_lru (
    .inv_vec    (inv_vec),
    .rank_in    (rank_cur),
    .hit        (hit),
    .hit_way    (hit_way),
    .tgt_way_c  (tgt_way),
    .rank_out_c (rank_new)
  );

  assign tgt_st = st_mem[idx_q][tgt_way];

  logic             is_rw, upd_en, fill, touch, rsp_hit_c, wb_c;
  mesi_t            new_st, rsp_state_c;
  logic [WAY_W-1:0] rsp_way_c;
  logic [TAG_W-1:0] wb_tag_c;

  // Outcome of the looked-up request, committed on the LOOKUP->UPDATE edge.
  always_comb begin
    is_rw       = 1'b0;
    upd_en      = 1'b0;
    fill        = 1'b0;
    touch       = 1'b0;
    rsp_hit_c   = 1'b0;
    wb_c        = 1'b0;
    new_st      = MESI_I;
    rsp_state_c = MESI_I;
    rsp_way_c   = '0;
    wb_tag_c    = tag_mem[idx_q][tgt_way];
    case (op_q)
      OP_READ, OP_WRITE: begin
        is_rw     = 1'b1;
        upd_en    = 1'b1;
        touch     = 1'b1;
        fill      = !hit;
        rsp_hit_c = hit;
        rsp_way_c = tgt_way;
        wb_c      = !hit && (tgt_st == MESI_M);
        if (op_q == OP_WRITE) new_st = MESI_M;
        else                  new_st = hit ? tgt_st : MESI_E;
        rsp_state_c = new_st;
      end
      OP_SNP_RD, OP_SNP_INV: begin
        if (hit) begin
          upd_en      = 1'b1;
          rsp_hit_c   = 1'b1;
          rsp_way_c   = tgt_way;
          wb_c        = (tgt_st == MESI_M);
          new_st      = (op_q == OP_SNP_RD) ? MESI_S : MESI_I;
          rsp_state_c = new_st;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FLUSH:  if (flush_idx_q == IDX_W'(SETS - 1)) state_d = ST_IDLE;
      ST_IDLE:   if (bus.req_valid) state_d = (bus.req_op == OP_FLUSH) ? ST_FLUSH : ST_LOOKUP;
      ST_LOOKUP: state_d = ST_UPDATE;
      ST_UPDATE: state_d = ST_IDLE;
      default:   state_d = ST_FLUSH;
    endcase
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_FLUSH;
      flush_idx_q   <= '0;
      op_q          <= '0;
      idx_q         <= '0;
      tag_q         <= '0;
      ready_q       <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_hit_q     <= 1'b0;
      rsp_way_q     <= '0;
      rsp_state_q   <= MESI_I;
      evict_wb_q    <= 1'b0;
      evict_index_q <= '0;
      evict_tag_q   <= '0;
      stat_hit_q    <= '0;
      stat_miss_q   <= '0;
      stat_read_q   <= '0;
      stat_write_q  <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= (state_d == ST_IDLE);
      rsp_valid_q <= (state_q == ST_LOOKUP);
      evict_wb_q  <= (state_q == ST_LOOKUP) && wb_c;
      flush_idx_q <= (state_q == ST_FLUSH) ? flush_idx_q + IDX_W'(1) : '0;
      if (state_q == ST_IDLE && bus.req_valid) begin
        op_q  <= bus.req_op;
        idx_q <= bus.req_index;
        tag_q <= bus.req_tag;
      end
      if (state_q == ST_LOOKUP) begin
        rsp_hit_q   <= rsp_hit_c;
        rsp_way_q   <= rsp_way_c;
        rsp_state_q <= rsp_state_c;
        if (wb_c) begin
          evict_index_q <= idx_q;
          evict_tag_q   <= wb_tag_c;
        end
        if (is_rw) begin
          if (hit) stat_hit_q  <= sat_inc(stat_hit_q);
          else     stat_miss_q <= sat_inc(stat_miss_q);
          if (op_q == OP_READ) stat_read_q  <= sat_inc(stat_read_q);
          else                 stat_write_q <= sat_inc(stat_write_q);
        end
      end
      if (state_q == ST_FLUSH) begin
        stat_hit_q   <= '0;
        stat_miss_q  <= '0;
        stat_read_q  <= '0;
        stat_write_q <= '0;
      end
    end
  end

  // Array writes: flush walk initialises one set per cycle, lookups commit their result.
  always_ff @(posedge clk) begin
    if (state_q == ST_FLUSH) begin
      for (int unsigned w = 0; w < WAYS; w++) begin
        st_mem[flush_idx_q][w]   <= MESI_I;
        rank_mem[flush_idx_q][w] <= WAY_W'(w);
      end
    end else if (state_q == ST_LOOKUP && upd_en) begin
      st_mem[idx_q][tgt_way] <= new_st;
      if (fill) tag_mem[idx_q][tgt_way] <= tag_q;
      if (touch) begin
        for (int unsigned w = 0; w < WAYS; w++) rank_mem[idx_q][w] <= rank_new[w];
      end
    end
  end

  assign bus.req_ready   = ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_hit     = rsp_hit_q;
  assign bus.rsp_way     = rsp_way_q;
  assign bus.rsp_state   = rsp_state_q;
  assign bus.evict_wb    = evict_wb_q;
  assign bus.evict_index = evict_index_q;
  assign bus.evict_tag   = evict_tag_q;
  assign bus.stat_hit    = stat_hit_q;
  assign bus.stat_miss   = stat_miss_q;
  assign bus.stat_read   = stat_read_q;
  assign bus.stat_write  = stat_write_q;

endmodule

// File: tb/tb_assoc_cache_ctrl.sv
// Scoreboard bench for assoc_cache_ctrl: queue-ordered LRU reference model, random and directed traffic.
module tb_assoc_cache_ctrl;
  import cache_pkg::*;

  localparam int WAYS    = 8;
  localparam int SETS    = 256;
  localparam int TAG_W   = 12;
  localparam int CNT_W   = 8;
  localparam int IDX_W   = $clog2(SETS);
  localparam int WAY_W   = $clog2(WAYS);
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  assoc_cache_ctrl_if #(.IDX_W(IDX_W), .TAG_W(TAG_W), .WAY_W(WAY_W), .CNT_W(CNT_W)) bus ();

  assoc_cache_ctrl #(.WAYS(WAYS), .SETS(SETS), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int hit; int way; int st; int wb; int wb_tag; int wb_idx;
    int c_hit; int c_miss; int c_rd; int c_wr; int acc;
  } exp_t;

  exp_t sbq[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference state: per-set tags/MESI plus an LRU order list (index 0 = least recent).
  int m_tag [SETS][WAYS];
  int m_st  [SETS][WAYS];
  int m_lru [SETS][WAYS];
  int m_hit, m_miss, m_rd, m_wr;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  function automatic void model_flush();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        m_st[s][w]  = 0;
        m_tag[s][w] = 0;
        m_lru[s][w] = w;
      end
    m_hit = 0; m_miss = 0; m_rd = 0; m_wr = 0;
  endfunction

  function automatic void touch(input int idx, input int way);
    int p = 0;
    for (int k = 0; k < WAYS; k++) if (m_lru[idx][k] == way) p = k;
    for (int k = p; k < WAYS - 1; k++) m_lru[idx][k] = m_lru[idx][k + 1];
    m_lru[idx][WAYS - 1] = way;
  endfunction

  function automatic exp_t model(input int op, input int idx, input int tag);
    exp_t e;
    int hw = -1;
    int tw = -1;
    e = '{default: 0};
    e.wb_idx = idx;
    for (int w = 0; w < WAYS; w++)
      if (hw < 0 && m_st[idx][w] != 0 && m_tag[idx][w] == tag) hw = w;
    if (op == 0 || op == 1) begin
      if (hw >= 0) begin
        tw = hw;
        e.hit = 1;
        m_hit = sat(m_hit);
        if (op == 1) m_st[idx][tw] = 3;
      end else begin
        for (int w = 0; w < WAYS; w++) if (tw < 0 && m_st[idx][w] == 0) tw = w;
        if (tw < 0) tw = m_lru[idx][0];
        e.wb = (m_st[idx][tw] == 3);
        e.wb_tag = m_tag[idx][tw];
        m_tag[idx][tw] = tag;
        m_st[idx][tw] = (op == 1) ? 3 : 2;
        m_miss = sat(m_miss);
      end
      if (op == 0) m_rd = sat(m_rd);
      else         m_wr = sat(m_wr);
      touch(idx, tw);
      e.way = tw;
      e.st  = m_st[idx][tw];
    end else if ((op == 3 || op == 4) && hw >= 0) begin
      e.hit = 1;
      e.way = hw;
      e.wb = (m_st[idx][hw] == 3);
      e.wb_tag = tag;
      m_st[idx][hw] = (op == 4) ? 1 : 0;
      e.st = m_st[idx][hw];
    end
    e.c_hit = m_hit; e.c_miss = m_miss; e.c_rd = m_rd; e.c_wr = m_wr;
    return e;
  endfunction

  // Monitor: every response pulse is matched against the oldest expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && bus.rsp_valid) begin
      if (sbq.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_rsp: got rsp_valid=1, expected no response at cycle %0d", cyc);
      end else begin
        e = sbq.pop_front();
        check("rsp_latency",  cyc, e.acc + 1);
        check("rsp_hit",      int'(bus.rsp_hit), e.hit);
        check("rsp_way",      int'(bus.rsp_way), e.way);
        check("rsp_state",    int'(bus.rsp_state), e.st);
        check("evict_wb",     int'(bus.evict_wb), e.wb);
        if (e.wb != 0) begin
          check("evict_tag",   int'(bus.evict_tag), e.wb_tag);
          check("evict_index", int'(bus.evict_index), e.wb_idx);
        end
        check("stat_hit",   int'(bus.stat_hit), e.c_hit);
        check("stat_miss",  int'(bus.stat_miss), e.c_miss);
        check("stat_read",  int'(bus.stat_read), e.c_rd);
        check("stat_write", int'(bus.stat_write), e.c_wr);
      end
    end else if (rst_n && bus.evict_wb) begin
      n_checks++; n_fail++;
      $display("FAIL stray_evict_wb: got evict_wb=1 without rsp_valid, expected 0 at cycle %0d", cyc);
    end
  end

  task automatic issue(input int op, input int idx, input int tag);
    exp_t e;
    int guard = 0;
    @(negedge clk);
    while (!bus.req_ready && guard < SETS + 20) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.req_ready) begin
      check("ready_timeout", int'(bus.req_ready), 1);
      return;
    end
    bus.req_valid = 1'b1;
    bus.req_op    = 4'(op);
    bus.req_index = IDX_W'(idx);
    bus.req_tag   = TAG_W'(tag);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    if (op == 8) begin
      model_flush();
    end else begin
      e = model(op, idx, tag);
      e.acc = cyc;
      sbq.push_back(e);
    end
  endtask

  // abort_after < 0: check the full flush walk; otherwise return that many cycles into it.
  task automatic apply_reset(input int abort_after);
    @(negedge clk);
    rst_n = 1'b0;
    sbq.delete();
    model_flush();
    repeat (2) @(negedge clk);
    check("rst_req_ready",   int'(bus.req_ready), 0);
    check("rst_rsp_valid",   int'(bus.rsp_valid), 0);
    check("rst_evict_wb",    int'(bus.evict_wb), 0);
    check("rst_rsp_hit",     int'(bus.rsp_hit), 0);
    check("rst_rsp_way",     int'(bus.rsp_way), 0);
    check("rst_rsp_state",   int'(bus.rsp_state), 0);
    check("rst_evict_index", int'(bus.evict_index), 0);
    check("rst_evict_tag",   int'(bus.evict_tag), 0);
    check("rst_stat_hit",    int'(bus.stat_hit), 0);
    check("rst_stat_miss",   int'(bus.stat_miss), 0);
    rst_n = 1'b1;
    if (abort_after >= 0) begin
      repeat (abort_after) @(posedge clk);
      return;
    end
    for (int k = 1; k <= SETS; k++) begin
      @(posedge clk);
      #1;
      if (k >= SETS - 1) check("ready_rise", int'(bus.req_ready), (k == SETS) ? 1 : 0);
      else if (bus.req_ready) check("ready_early", int'(bus.req_ready), 0);
    end
    check("post_flush_stat_read",  int'(bus.stat_read), 0);
    check("post_flush_stat_write", int'(bus.stat_write), 0);
  endtask

  int ops[10] = '{0, 0, 0, 1, 1, 1, 3, 4, 2, 12};

  initial begin
    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_index = '0;
    bus.req_tag   = '0;
    apply_reset(-1);

    issue(0, 5, 'h123);
    issue(0, 5, 'h123);

    for (int t = 0; t < 9; t++) issue(0, 7, 'h200 + t);

    issue(1, 2, 'hABC);
    issue(4, 2, 'hABC);
    issue(3, 2, 'hABC);

    for (int t = 0; t < 8; t++) issue(1, 3, 'h300 + t);
    issue(0, 3, 'h302);
    issue(1, 3, 'h3FF);
    issue(1, 3, 'h3FE);

    issue(2, 4, 1);
    issue(15, 4, 1);
    issue(4, 4, 'h777);
    issue(3, 4, 'h777);

    repeat (1000) begin
      issue(ops[$urandom_range(0, 9)], $urandom_range(0, 3), $urandom_range(0, 11));
    end

    issue(8, 0, 0);
    issue(0, 5, 'h123);
    issue(1, 5, 'h123);

    issue(0, 9, 'h55);
    apply_reset(-1);

    apply_reset(101);
    apply_reset(-1);
    issue(0, 1, 1);

    repeat (6) @(negedge clk);
    check("scoreboard_drained", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
